// File: rtl/imu_pkt_pkg.sv
// Shared types and defaults for the IMU packet receive path.
package imu_pkt_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HUNT    = 3'd1,
    COLLECT = 3'd2,
    CHECK   = 3'd3,
    FLUSH   = 3'd4
  } imu_state_t;

  localparam int          IMU_PKT_SIZE_DEF   = 46;
  localparam logic [15:0] IMU_PKT_HEADER_DEF = 16'h5AA5;

  // Index width must also hold the value IMU_PKT_SIZE (end-of-burst marker).
  function automatic int idx_width(input int pkt_size);
    return $clog2(pkt_size + 1);
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/imu_pkt_buf.sv
// One-packet byte buffer: single write port, registered read port.
module imu_pkt_buf
  import imu_pkt_pkg::*;
#(
  parameter int DEPTH = IMU_PKT_SIZE_DEF,
  parameter int IDX_W = idx_width(IMU_PKT_SIZE_DEF)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [7:0]       wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [7:0]       rd_data
);

  localparam logic [IDX_W-1:0] LIM = IDX_W'(DEPTH);

  logic [7:0] r_mem [DEPTH];
  logic [7:0] r_rd_data;

  // Byte storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (wr_en && (wr_idx < LIM)) begin
      r_mem[wr_idx] <= wr_data;
    end
  end

  // Registered read port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_data <= 8'h00;
    end else if (rd_idx < LIM) begin
      r_rd_data <= r_mem[rd_idx];
    end
  end

  assign rd_data = r_rd_data;

endmodule

// File: rtl/imu_pkt_rx_ctrl.sv
// IMU packet write-side controller: header hunt, collect, validate, burst to FIFO.
// Optional macro IMU_CHECKSUM_EN enables the payload checksum comparison.
module imu_pkt_rx_ctrl
  import imu_pkt_pkg::*;
#(
  parameter int          IMU_PKT_SIZE   = IMU_PKT_SIZE_DEF,
  parameter logic [15:0] IMU_PKT_HEADER = IMU_PKT_HEADER_DEF,
  parameter int          FIFO_DEPTH     = 1024,
  parameter int          FIFO_CNT_W     = 10,
  parameter int          TIMEOUT_CYC    = 4096
) (
  input  logic                  sys_clk,
  input  logic                  reset,
  input  logic                  rx_vld,
  input  logic [7:0]            rx_data,
  input  logic                  insert_en_async,
  input  logic [FIFO_CNT_W-1:0] fifo_wr_count,
  output logic                  fifo_wr_en,
  output logic [7:0]            fifo_din,
  output logic [15:0]           pkt_ok_cnt,
  output logic [15:0]           pkt_drop_cnt,
  output logic                  hunting
);

  localparam int                  IDX_W     = idx_width(IMU_PKT_SIZE);
  localparam int                  TMR_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(IMU_PKT_SIZE - 1);
  localparam logic [IDX_W-1:0]    PKT_LEN   = IDX_W'(IMU_PKT_SIZE);
  localparam logic [TMR_W-1:0]    TMR_LAST  = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [FIFO_CNT_W:0] CNT_DEPTH = (FIFO_CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [FIFO_CNT_W:0] CNT_PKT   = (FIFO_CNT_W + 1)'(IMU_PKT_SIZE);

  imu_state_t       r_state;
  logic             r_ins_s1, r_ins_s2;
  logic [15:0]      r_det;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_rd;
  logic [TMR_W-1:0] r_tmr;
  logic             r_wr_en;
  logic [15:0]      r_ok_cnt, r_drop_cnt;
  logic             r_hunting;

  logic             w_ins;
  logic             w_sum_ok;
  logic             w_room;
  logic [FIFO_CNT_W:0] w_space;
  logic             w_buf_we;
  logic [IDX_W-1:0] w_buf_widx;
  logic [7:0]       w_buf_rdata;

  // Two-flop synchronizer for the pix_clk-domain insertion enable.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_ins_s1 <= 1'b0;
      r_ins_s2 <= 1'b0;
    end else begin
      r_ins_s1 <= insert_en_async;
      r_ins_s2 <= r_ins_s1;
    end
  end

  assign w_ins   = r_ins_s2;
  assign w_space = CNT_DEPTH - {1'b0, fifo_wr_count};
  assign w_room  = (w_space >= CNT_PKT);

`ifdef IMU_CHECKSUM_EN
  logic [7:0] r_sum;
  logic       r_sum_ok;

  // Payload sum; the trailing byte is compared as it arrives.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_sum    <= 8'h00;
      r_sum_ok <= 1'b0;
    end else if (r_state == HUNT) begin
      r_sum <= 8'h00;
    end else if ((r_state == COLLECT) && rx_vld) begin
      if (r_idx == LAST_IDX) begin
        r_sum_ok <= (rx_data == r_sum);
      end else begin
        r_sum <= r_sum + rx_data;
      end
    end
  end

  assign w_sum_ok = r_sum_ok;
`else
  assign w_sum_ok = 1'b1;
`endif

  // Buffer writes. In HUNT a byte that follows the first header byte lands in
  // slot 1, any other in slot 0, so slots 0..1 hold the header at lock time.
  always_comb begin
    w_buf_we   = 1'b0;
    w_buf_widx = r_idx;
    if (rx_vld && w_ins && (r_state == HUNT) && (r_det != IMU_PKT_HEADER)) begin
      w_buf_we   = 1'b1;
      w_buf_widx = (r_det[7:0] == IMU_PKT_HEADER[15:8]) ? IDX_W'(1) : IDX_W'(0);
    end else if (rx_vld && w_ins && (r_state == COLLECT)) begin
      w_buf_we   = 1'b1;
    end else begin
      w_buf_we   = 1'b0;
    end
  end

  imu_pkt_buf #(
    .DEPTH (IMU_PKT_SIZE),
    .IDX_W (IDX_W)
  ) u_buf (
    .clk     (sys_clk),
    .reset   (reset),
    .wr_en   (w_buf_we),
    .wr_idx  (w_buf_widx),
    .wr_data (rx_data),
    .rd_idx  (r_rd),
    .rd_data (w_buf_rdata)
  );

  // Main packet FSM with registered status outputs.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_det      <= 16'h0000;
      r_idx      <= '0;
      r_rd       <= '0;
      r_tmr      <= '0;
      r_wr_en    <= 1'b0;
      r_ok_cnt   <= 16'h0000;
      r_drop_cnt <= 16'h0000;
      r_hunting  <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          r_det     <= 16'h0000;
          r_hunting <= 1'b1;
          if (w_ins) begin
            r_state <= HUNT;
          end
        end
        HUNT: begin
          if (!w_ins) begin
            r_state <= IDLE;
          end else if (r_det == IMU_PKT_HEADER) begin
            r_state   <= COLLECT;
            r_det     <= 16'h0000;
            r_idx     <= IDX_W'(2);
            r_tmr     <= '0;
            r_hunting <= 1'b0;
          end else if (rx_vld) begin
            r_det <= {r_det[7:0], rx_data};
          end
        end
        COLLECT: begin
          if (!w_ins) begin
            r_state   <= IDLE;
            r_hunting <= 1'b1;
          end else if (rx_vld) begin
            r_tmr <= '0;
            r_idx <= r_idx + IDX_W'(1);
            if (r_idx == LAST_IDX) begin
              r_state <= CHECK;
            end
          end else if (r_tmr == TMR_LAST) begin
            r_drop_cnt <= sat_inc16(r_drop_cnt);
            r_state    <= HUNT;
            r_hunting  <= 1'b1;
          end else begin
            r_tmr <= r_tmr + TMR_W'(1);
          end
        end
        CHECK: begin
          if (rx_vld) begin
            r_det <= {r_det[7:0], rx_data};
          end
          if (w_sum_ok && w_room) begin
            r_state <= FLUSH;
            r_wr_en <= 1'b1;
            r_rd    <= IDX_W'(1);
          end else begin
            r_drop_cnt <= sat_inc16(r_drop_cnt);
            r_state    <= w_ins ? HUNT : IDLE;
            r_hunting  <= 1'b1;
          end
        end
        FLUSH: begin
          if (rx_vld) begin
            r_det <= {r_det[7:0], rx_data};
          end
          // r_rd runs one ahead of the byte on fifo_din (registered read).
          if (r_rd == PKT_LEN) begin
            r_wr_en   <= 1'b0;
            r_rd      <= '0;
            r_ok_cnt  <= sat_inc16(r_ok_cnt);
            r_state   <= w_ins ? HUNT : IDLE;
            r_hunting <= 1'b1;
          end else begin
            r_rd <= r_rd + IDX_W'(1);
          end
        end
        default: begin
          r_state   <= IDLE;
          r_wr_en   <= 1'b0;
          r_rd      <= '0;
          r_hunting <= 1'b1;
        end
      endcase
    end
  end

  assign fifo_wr_en   = r_wr_en;
  assign fifo_din     = w_buf_rdata;
  assign pkt_ok_cnt   = r_ok_cnt;
  assign pkt_drop_cnt = r_drop_cnt;
  assign hunting      = r_hunting;

endmodule
